// File: rtl/axi_master_multi_counter.sv
// Multi-channel up/down counter with variable step and programmable full limit.
// Each channel can saturate or wrap and has registered zero/full flags and
// sticky overflow/underflow flags.
module axi_master_multi_counter #(
    parameter int                 C_WIDTH      = 8,
    parameter int                 C_NUM_CH     = 2,
    parameter int                 C_STEP_WIDTH = 4,
    parameter logic [C_WIDTH-1:0] C_INIT       = '0,
    parameter bit                 C_SATURATE   = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clken,
    input  logic [C_NUM_CH-1:0]              load,
    input  logic [C_NUM_CH*C_WIDTH-1:0]      load_value,
    input  logic [C_NUM_CH-1:0]              incr,
    input  logic [C_NUM_CH*C_STEP_WIDTH-1:0] incr_step,
    input  logic [C_NUM_CH-1:0]              decr,
    input  logic [C_NUM_CH*C_STEP_WIDTH-1:0] decr_step,
    input  logic [C_NUM_CH*C_WIDTH-1:0]      limit,
    input  logic [C_NUM_CH-1:0]              clr_err,
    output logic [C_NUM_CH*C_WIDTH-1:0]      count,
    output logic [C_NUM_CH-1:0]              is_zero,
    output logic [C_NUM_CH-1:0]              is_full,
    output logic [C_NUM_CH-1:0]              ovf,
    output logic [C_NUM_CH-1:0]              udf
);

    // Two guard bits: bit W flags a carry past all-ones, bit W+1 is the sign.
    localparam int SUM_W = C_WIDTH + 2;
    localparam int PAD_W = SUM_W - C_STEP_WIDTH;

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_CH; gi++) begin : g_ch
            logic [C_WIDTH-1:0] count_reg;
            logic               is_zero_reg;
            logic               is_full_reg;
            logic               ovf_reg;
            logic               udf_reg;

            logic [C_WIDTH-1:0] count_next;
            logic               ovf_evt;
            logic               udf_evt;
            logic [SUM_W-1:0]   sum;
            logic [SUM_W-1:0]   incr_ext;
            logic [SUM_W-1:0]   decr_ext;

            // Next count: load wins, otherwise signed add/sub with clamp or wrap.
            always_comb begin
                incr_ext   = incr[gi] ? {{PAD_W{1'b0}}, incr_step[gi*C_STEP_WIDTH +: C_STEP_WIDTH]} : '0;
                decr_ext   = decr[gi] ? {{PAD_W{1'b0}}, decr_step[gi*C_STEP_WIDTH +: C_STEP_WIDTH]} : '0;
                sum        = {2'b00, count_reg} + incr_ext - decr_ext;
                count_next = sum[C_WIDTH-1:0];
                ovf_evt    = 1'b0;
                udf_evt    = 1'b0;
                if (load[gi]) begin
                    count_next = load_value[gi*C_WIDTH +: C_WIDTH];
                end else if (sum[SUM_W-1]) begin
                    // Negative result: went below zero.
                    udf_evt = 1'b1;
                    if (C_SATURATE) begin
                        count_next = '0;
                    end
                end else if (sum[C_WIDTH]) begin
                    // Positive result beyond all-ones.
                    ovf_evt = 1'b1;
                    if (C_SATURATE) begin
                        count_next = '1;
                    end
                end
            end

            // Count, flags and sticky errors; a same-cycle event beats clr_err.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg   <= C_INIT;
                    is_zero_reg <= (C_INIT == '0);
                    is_full_reg <= 1'b0;
                    ovf_reg     <= 1'b0;
                    udf_reg     <= 1'b0;
                end else if (clken) begin
                    count_reg   <= count_next;
                    is_zero_reg <= (count_next == '0);
                    is_full_reg <= (count_next >= limit[gi*C_WIDTH +: C_WIDTH]);
                    ovf_reg     <= ovf_evt | (ovf_reg & ~clr_err[gi]);
                    udf_reg     <= udf_evt | (udf_reg & ~clr_err[gi]);
                end
            end

            assign count[gi*C_WIDTH +: C_WIDTH] = count_reg;
            assign is_zero[gi]                  = is_zero_reg;
            assign is_full[gi]                  = is_full_reg;
            assign ovf[gi]                      = ovf_reg;
            assign udf[gi]                      = udf_reg;
        end
    endgenerate

endmodule

// File: tb/tb_axi_master_multi_counter.sv
// Directed bench: a saturating and a wrapping instance (W=4, 2 channels) share
// stimulus; channel 1 is never driven. Status packs {count, zero, full, ovf, udf}.
module tb_axi_master_multi_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clken = 1'b1;
    logic [1:0] load = '0, incr = '0, decr = '0, clr_err = '0;
    logic [7:0] load_value = '0, incr_step = '0, decr_step = '0;
    logic [7:0] limit = {4'd15, 4'd12};

    logic [7:0] s_count, w_count;
    logic [1:0] s_zero, s_full, s_ovf, s_udf;
    logic [1:0] w_zero, w_full, w_ovf, w_udf;
    logic [7:0] s_st0, w_st0, s_st1, w_st1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    axi_master_multi_counter #(
        .C_WIDTH(4), .C_NUM_CH(2), .C_STEP_WIDTH(4), .C_INIT(4'd0), .C_SATURATE(1'b1)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .clken(clken), .load(load), .load_value(load_value),
        .incr(incr), .incr_step(incr_step), .decr(decr), .decr_step(decr_step),
        .limit(limit), .clr_err(clr_err), .count(s_count), .is_zero(s_zero),
        .is_full(s_full), .ovf(s_ovf), .udf(s_udf)
    );

    axi_master_multi_counter #(
        .C_WIDTH(4), .C_NUM_CH(2), .C_STEP_WIDTH(4), .C_INIT(4'd0), .C_SATURATE(1'b0)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n), .clken(clken), .load(load), .load_value(load_value),
        .incr(incr), .incr_step(incr_step), .decr(decr), .decr_step(decr_step),
        .limit(limit), .clr_err(clr_err), .count(w_count), .is_zero(w_zero),
        .is_full(w_full), .ovf(w_ovf), .udf(w_udf)
    );

    assign s_st0 = {s_count[3:0], s_zero[0], s_full[0], s_ovf[0], s_udf[0]};
    assign w_st0 = {w_count[3:0], w_zero[0], w_full[0], w_ovf[0], w_udf[0]};
    assign s_st1 = {s_count[7:4], s_zero[1], s_full[1], s_ovf[1], s_udf[1]};
    assign w_st1 = {w_count[7:4], w_zero[1], w_full[1], w_ovf[1], w_udf[1]};

    // Advance one clock and settle past the edge; one line per transaction.
    task automatic cyc();
        @(posedge clk);
        #1;
        $display("[TB] t=%0t ch0 sat=%b wrap=%b", $time, s_st0, w_st0);
    endtask

    // Channel-0 stimulus for the next edge; channel 1 stays idle.
    task automatic drive0(input bit ld, input logic [3:0] lv, input bit inc,
                          input logic [3:0] istep, input bit dec,
                          input logic [3:0] dstep, input bit clr);
        load[0]          = ld;
        load_value[3:0]  = lv;
        incr[0]          = inc;
        incr_step[3:0]   = istep;
        decr[0]          = dec;
        decr_step[3:0]   = dstep;
        clr_err[0]       = clr;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (s_st0 !== {4'd0, 4'b1000}) begin
            tests_failed++;
            $display("FAIL reset_sat act=%b exp=%b", s_st0, {4'd0, 4'b1000});
        end
        tests_run++;
        if (w_st0 !== {4'd0, 4'b1000}) begin
            tests_failed++;
            $display("FAIL reset_wrap act=%b exp=%b", w_st0, {4'd0, 4'b1000});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_simultaneous();
        drive0(1, 4'd5, 0, 4'd0, 0, 4'd0, 0);
        cyc();
        tests_run++;
        if (s_st0 !== {4'd5, 4'b0000}) begin
            tests_failed++;
            $display("FAIL load5 act=%b exp=%b", s_st0, {4'd5, 4'b0000});
        end
        drive0(0, 4'd0, 1, 4'd3, 1, 4'd1, 0);
        cyc();
        tests_run++;
        if (s_st0 !== {4'd7, 4'b0000}) begin
            tests_failed++;
            $display("FAIL inc3_dec1_sat act=%b exp=%b", s_st0, {4'd7, 4'b0000});
        end
        tests_run++;
        if (w_st0 !== {4'd7, 4'b0000}) begin
            tests_failed++;
            $display("FAIL inc3_dec1_wrap act=%b exp=%b", w_st0, {4'd7, 4'b0000});
        end
        drive0(0, 4'd0, 1, 4'd2, 1, 4'd2, 0);
        cyc();
        tests_run++;
        if (s_st0 !== {4'd7, 4'b0000}) begin
            tests_failed++;
            $display("FAIL equal_steps_sat act=%b exp=%b", s_st0, {4'd7, 4'b0000});
        end
        tests_run++;
        if (w_st0 !== {4'd7, 4'b0000}) begin
            tests_failed++;
            $display("FAIL equal_steps_wrap act=%b exp=%b", w_st0, {4'd7, 4'b0000});
        end
    endtask

    task automatic test_saturate_wrap();
        drive0(1, 4'd14, 0, 4'd0, 0, 4'd0, 0);
        cyc();
        tests_run++;
        if (s_st0 !== {4'd14, 4'b0100}) begin
            tests_failed++;
            $display("FAIL load14 act=%b exp=%b", s_st0, {4'd14, 4'b0100});
        end
        drive0(0, 4'd0, 1, 4'd3, 0, 4'd0, 0);
        cyc();
        tests_run++;
        if (s_st0 !== {4'd15, 4'b0110}) begin
            tests_failed++;
            $display("FAIL ovf_sat act=%b exp=%b", s_st0, {4'd15, 4'b0110});
        end
        tests_run++;
        if (w_st0 !== {4'd1, 4'b0010}) begin
            tests_failed++;
            $display("FAIL ovf_wrap act=%b exp=%b", w_st0, {4'd1, 4'b0010});
        end
        drive0(0, 4'd0, 0, 4'd0, 0, 4'd0, 0);
        cyc();
        cyc();
        tests_run++;
        if (s_st0 !== {4'd15, 4'b0110}) begin
            tests_failed++;
            $display("FAIL ovf_held_sat act=%b exp=%b", s_st0, {4'd15, 4'b0110});
        end
        tests_run++;
        if (w_st0 !== {4'd1, 4'b0010}) begin
            tests_failed++;
            $display("FAIL ovf_held_wrap act=%b exp=%b", w_st0, {4'd1, 4'b0010});
        end
        drive0(1, 4'd2, 0, 4'd0, 0, 4'd0, 0);
        cyc();
        tests_run++;
        if (w_st0 !== {4'd2, 4'b0010}) begin
            tests_failed++;
            $display("FAIL load2_keeps_ovf act=%b exp=%b", w_st0, {4'd2, 4'b0010});
        end
        drive0(0, 4'd0, 0, 4'd0, 1, 4'd7, 0);
        cyc();
        tests_run++;
        if (s_st0 !== {4'd0, 4'b1011}) begin
            tests_failed++;
            $display("FAIL udf_sat act=%b exp=%b", s_st0, {4'd0, 4'b1011});
        end
        tests_run++;
        if (w_st0 !== {4'd11, 4'b0011}) begin
            tests_failed++;
            $display("FAIL udf_wrap act=%b exp=%b", w_st0, {4'd11, 4'b0011});
        end
        drive0(1, 4'd1, 0, 4'd0, 0, 4'd0, 0);
        cyc();
        tests_run++;
        if (s_st0 !== {4'd1, 4'b0011}) begin
            tests_failed++;
            $display("FAIL load1 act=%b exp=%b", s_st0, {4'd1, 4'b0011});
        end
        drive0(0, 4'd0, 0, 4'd0, 1, 4'd2, 0);
        cyc();
        tests_run++;
        if (s_st0 !== {4'd0, 4'b1011}) begin
            tests_failed++;
            $display("FAIL dec2_sat act=%b exp=%b", s_st0, {4'd0, 4'b1011});
        end
        tests_run++;
        if (w_st0 !== {4'd15, 4'b0111}) begin
            tests_failed++;
            $display("FAIL dec2_wrap act=%b exp=%b", w_st0, {4'd15, 4'b0111});
        end
    endtask

    task automatic test_load_limit();
        limit[3:0] = 4'd9;
        drive0(1, 4'd9, 1, 4'd1, 0, 4'd0, 0);
        cyc();
        tests_run++;
        if (s_st0 !== {4'd9, 4'b0111}) begin
            tests_failed++;
            $display("FAIL load_over_incr_sat act=%b exp=%b", s_st0, {4'd9, 4'b0111});
        end
        tests_run++;
        if (w_st0 !== {4'd9, 4'b0111}) begin
            tests_failed++;
            $display("FAIL load_over_incr_wrap act=%b exp=%b", w_st0, {4'd9, 4'b0111});
        end
        limit[3:0] = 4'd10;
        drive0(0, 4'd0, 0, 4'd0, 0, 4'd0, 0);
        cyc();
        tests_run++;
        if (s_st0 !== {4'd9, 4'b0011}) begin
            tests_failed++;
            $display("FAIL limit10_sat act=%b exp=%b", s_st0, {4'd9, 4'b0011});
        end
        tests_run++;
        if (w_st0 !== {4'd9, 4'b0011}) begin
            tests_failed++;
            $display("FAIL limit10_wrap act=%b exp=%b", w_st0, {4'd9, 4'b0011});
        end
    endtask

    task automatic test_clken_hold();
        clken = 1'b0;
        limit[3:0] = 4'd2;
        drive0(1, 4'd3, 1, 4'd4, 0, 4'd0, 1);
        cyc();
        cyc();
        tests_run++;
        if (s_st0 !== {4'd9, 4'b0011}) begin
            tests_failed++;
            $display("FAIL clken_hold_sat act=%b exp=%b", s_st0, {4'd9, 4'b0011});
        end
        tests_run++;
        if (w_st0 !== {4'd9, 4'b0011}) begin
            tests_failed++;
            $display("FAIL clken_hold_wrap act=%b exp=%b", w_st0, {4'd9, 4'b0011});
        end
        limit[3:0] = 4'd10;
        drive0(0, 4'd0, 0, 4'd0, 0, 4'd0, 0);
        clken = 1'b1;
    endtask

    task automatic test_clr_err();
        drive0(1, 4'd15, 0, 4'd0, 0, 4'd0, 0);
        cyc();
        drive0(0, 4'd0, 1, 4'd1, 0, 4'd0, 1);
        cyc();
        tests_run++;
        if (s_st0 !== {4'd15, 4'b0110}) begin
            tests_failed++;
            $display("FAIL clr_vs_ovf_sat act=%b exp=%b", s_st0, {4'd15, 4'b0110});
        end
        tests_run++;
        if (w_st0 !== {4'd0, 4'b1010}) begin
            tests_failed++;
            $display("FAIL clr_vs_ovf_wrap act=%b exp=%b", w_st0, {4'd0, 4'b1010});
        end
        drive0(0, 4'd0, 0, 4'd0, 0, 4'd0, 1);
        cyc();
        tests_run++;
        if (s_st0 !== {4'd15, 4'b0100}) begin
            tests_failed++;
            $display("FAIL clr_alone_sat act=%b exp=%b", s_st0, {4'd15, 4'b0100});
        end
        tests_run++;
        if (w_st0 !== {4'd0, 4'b1000}) begin
            tests_failed++;
            $display("FAIL clr_alone_wrap act=%b exp=%b", w_st0, {4'd0, 4'b1000});
        end
        drive0(0, 4'd0, 0, 4'd0, 0, 4'd0, 0);
    endtask

    task automatic test_isolation();
        tests_run++;
        if (s_st1 !== {4'd0, 4'b1000}) begin
            tests_failed++;
            $display("FAIL ch1_isolated_sat act=%b exp=%b", s_st1, {4'd0, 4'b1000});
        end
        tests_run++;
        if (w_st1 !== {4'd0, 4'b1000}) begin
            tests_failed++;
            $display("FAIL ch1_isolated_wrap act=%b exp=%b", w_st1, {4'd0, 4'b1000});
        end
    endtask

    task automatic test_reset_mid();
        drive0(1, 4'd15, 0, 4'd0, 0, 4'd0, 0);
        cyc();
        drive0(0, 4'd0, 1, 4'd6, 0, 4'd0, 0);
        cyc();
        tests_run++;
        if (s_st0 !== {4'd15, 4'b0110}) begin
            tests_failed++;
            $display("FAIL pre_rst_sat act=%b exp=%b", s_st0, {4'd15, 4'b0110});
        end
        tests_run++;
        if (w_st0 !== {4'd5, 4'b0010}) begin
            tests_failed++;
            $display("FAIL pre_rst_wrap act=%b exp=%b", w_st0, {4'd5, 4'b0010});
        end
        // Incr stays asserted while reset drops between edges.
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (s_st0 !== {4'd0, 4'b1000}) begin
            tests_failed++;
            $display("FAIL async_rst_sat act=%b exp=%b", s_st0, {4'd0, 4'b1000});
        end
        tests_run++;
        if (w_st0 !== {4'd0, 4'b1000}) begin
            tests_failed++;
            $display("FAIL async_rst_wrap act=%b exp=%b", w_st0, {4'd0, 4'b1000});
        end
        drive0(0, 4'd0, 0, 4'd0, 0, 4'd0, 0);
        @(negedge clk) rst_n = 1'b1;
        cyc();
        tests_run++;
        if (s_st0 !== {4'd0, 4'b1000}) begin
            tests_failed++;
            $display("FAIL post_rst_sat act=%b exp=%b", s_st0, {4'd0, 4'b1000});
        end
        tests_run++;
        if (w_st0 !== {4'd0, 4'b1000}) begin
            tests_failed++;
            $display("FAIL post_rst_wrap act=%b exp=%b", w_st0, {4'd0, 4'b1000});
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_saturate_wrap();
        test_load_limit();
        test_clken_hold();
        test_clr_err();
        test_isolation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
